ft_recovery_seq: RTL and testbench
==================================

# ft_recovery_seq

Sequences architectural state restore after a lockstep mismatch. It sits between the fault-tolerance controller and the core pair. It starts when the controller raises its recover request, then copies the checkpointed register file and PC back into the cores. When the copy is complete it pulses recovery-done back to the controller. All work is strictly sequential: one register per cycle, pipelined against a 1-cycle-latency checkpoint store.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; x0 is not restored.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NREGS.
- DATA_W, 32, register and PC width.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  sequence start allowed; sampled only in IDLE.
- recover_i  in  1  recover request level from the FT controller; the sequence starts on its rising edge.
- ckpt_raddr_o  out  ADDR_W  checkpoint store read address.
- ckpt_rdata_i  in  DATA_W  checkpoint read data, valid one cycle after the address.
- ckpt_pc_i  in  DATA_W  checkpointed PC, stable during a sequence.
- rf_we_o  out  1  core register-file write enable, driven to both cores.
- rf_waddr_o  out  ADDR_W  write address.
- rf_wdata_o  out  DATA_W  write data.
- pc_we_o  out  1  PC load strobe.
- pc_o  out  DATA_W  PC load value.
- busy_o  out  1  high from cycle 1 through the done cycle.
- recovery_done_o  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, RESTORE, LOAD_PC, DONE.
- IDLE -> RESTORE when recover_i is high, the registered recover_q is low, and enable_i is high. The read counter loads 1.
- RESTORE issues one read per cycle: ckpt_raddr_o = counter, for counter = 1 .. NREGS-1.
  - A write stage registered one cycle behind the read stage produces rf_we_o=1, rf_waddr_o = previous address, rf_wdata_o = ckpt_rdata_i.
  - After the read of NREGS-1 is issued, go to LOAD_PC. The write of NREGS-1 occurs in the LOAD_PC cycle.
- LOAD_PC: pc_we_o=1, pc_o = ckpt_pc_i. In this cycle the last register write is still active. Then go to DONE.
- DONE: recovery_done_o=1 for one cycle, then return to IDLE.
- Edge detect: recover_q is updated every cycle. A held level never retriggers; the controller must drop recover_i and raise it again to start another sequence.
- A rising edge of recover_i while not in IDLE is ignored and is not queued.
- enable_i low mid-sequence has no effect. The sequence always completes, so no partial restore is possible.
- Reset at any point forces IDLE and all outputs to their reset values. Any partial restore is abandoned; the cores are held in reset by the controller anyway.

## Timing
- Cycle 0: the clock edge that samples the recover_i rising edge in IDLE.
- Cycle k, for 1 <= k <= NREGS-1: ckpt_raddr_o = k.
- Cycle k+1: rf_we_o=1, rf_waddr_o = k.
- Cycle NREGS: LOAD_PC (pc_we_o=1) together with the last rf write.
- Cycle NREGS+1: recovery_done_o=1.
- Total latency is NREGS+1 cycles from the start edge to done. With defaults: writes in cycles 2..32, PC load in cycle 32, done in cycle 33.
- Reset values: ckpt_raddr_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pc_we_o=0, pc_o=0, busy_o=0, recovery_done_o=0, recover_q=0, state=IDLE.
- rf_we_o, pc_we_o and recovery_done_o are never asserted outside their stated cycles.
- The counter compares against NREGS-1 and never wraps. With NREGS = 2**ADDR_W, the last address is all-ones, and the next-count logic must not overflow into address 0.

## Structure
- ft_pkg: state enum typedef ft_rseq_state_e {IDLE, RESTORE, LOAD_PC, DONE}. The package also holds the default NREGS/ADDR_W/DATA_W localparams shared with ft_control and the checkpoint store.
- Sub-module ft_edge_detect (rising edge with async active-low reset). It is reused for error_i conditioning in ft_control.
- The read counter and write-stage registers live in the top module; no further hierarchy.

## Test plan
- Basic restore: preload the checkpoint with reg[i]=0xA000_0000+i and PC=0x0000_0180, then pulse recover_i. Required response:
  - 31 writes, address i with data 0xA000_0000+i, in cycles 2..32.
  - pc_we_o with 0x180 in cycle 32.
  - recovery_done_o in cycle 33, busy_o low in cycle 34.
- Held level: hold recover_i high for 100 cycles -> exactly one sequence and exactly one done pulse.
- Gated: enable_i=0 with a recover_i rising edge in IDLE -> no writes and no done. Raise enable_i while recover_i is still high -> still no start. Only a new edge starts.
- Retrigger while busy: a second recover_i rising edge at cycle 10 -> ignored. Exactly 31 writes, a single done, and the sequence is not extended.
- Reset mid-operation: assert rst_ni low at cycle 15 -> all outputs 0 asynchronously. After release, a fresh recover_i edge yields a full 31-write sequence starting at address 1.
- Parameter sweep: NREGS=4, ADDR_W=2 -> writes to addresses 1..3, PC load in cycle 4, done in cycle 5, address never wraps to 0.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types and default sizing for the fault-tolerance recovery path
// (sequencer, controller and checkpoint store).
package ft_pkg;

  localparam int FT_NREGS  = 32;
  localparam int FT_ADDR_W = 5;
  localparam int FT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RESTORE,
    LOAD_PC,
    DONE
  } ft_rseq_state_e;

endpackage

// File: rtl/ft_recovery_seq_if.sv
// Checkpoint read port plus core register-file / PC load port of the
// recovery sequencer. master = sequencer, slave = store/core side.
interface ft_recovery_seq_if
  import ft_pkg::*;
#(
  parameter int ADDR_W = FT_ADDR_W,
  parameter int DATA_W = FT_DATA_W
);

  logic [ADDR_W-1:0] ckpt_raddr_o;
  logic [DATA_W-1:0] ckpt_rdata_i;
  logic [DATA_W-1:0] ckpt_pc_i;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic              pc_we_o;
  logic [DATA_W-1:0] pc_o;

  modport master (
    output ckpt_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_we_o, pc_o,
    input  ckpt_rdata_i, ckpt_pc_i
  );

  modport slave (
    input  ckpt_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_we_o, pc_o,
    output ckpt_rdata_i, ckpt_pc_i
  );

endinterface

// File: rtl/ft_edge_detect.sv
// Registered rising-edge detector; the history flop updates every cycle so
// a held level produces exactly one rise.
module ft_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q <= 1'b0;
    else         q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/ft_recovery_seq.sv
// Restores the checkpointed register file (x1..NREGS-1) and PC into the core
// pair after a lockstep mismatch, then pulses recovery_done_o.
//
// state   | meaning
// IDLE    | waiting for an enabled recover_i rising edge
// RESTORE | one checkpoint read per cycle, write stage one cycle behind
// LOAD_PC | last register write plus PC load strobe
// DONE    | single-cycle completion pulse, then back to IDLE
module ft_recovery_seq
  import ft_pkg::*;
#(
  parameter int NREGS  = FT_NREGS,
  parameter int ADDR_W = FT_ADDR_W,
  parameter int DATA_W = FT_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                recover_i,
  ft_recovery_seq_if.master   bus,
  output logic                busy_o,
  output logic                recovery_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  ft_rseq_state_e    state;
  logic              rec_rise;
  logic [ADDR_W-1:0] cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              pc_we_q;
  logic [DATA_W-1:0] pc_q;
  logic              busy_q;
  logic              done_q;

  ft_edge_detect u_rec_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (recover_i),
    .rise   (rec_rise)
  );

  // The counter is compared before incrementing, so it stops at LAST_ADDR
  // even when NREGS == 2**ADDR_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      pc_we_q <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q    <= 1'b0;
      pc_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (rec_rise && enable_i) begin
            state  <= RESTORE;
            cnt    <= FIRST_ADDR;
            busy_q <= 1'b1;
          end
        end
        RESTORE: begin
          wr_q    <= 1'b1;
          waddr_q <= cnt;
          if (cnt == LAST_ADDR) begin
            state   <= LOAD_PC;
            cnt     <= '0;
            pc_we_q <= 1'b1;
            pc_q    <= bus.ckpt_pc_i;
          end else begin
            cnt <= cnt + FIRST_ADDR;
          end
        end
        LOAD_PC: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store data arrives in the write cycle itself, so it is forwarded
  // directly and forced to zero whenever no write is active.
  assign bus.ckpt_raddr_o = cnt;
  assign bus.rf_we_o      = wr_q;
  assign bus.rf_waddr_o   = waddr_q;
  assign bus.rf_wdata_o   = wr_q ? bus.ckpt_rdata_i : '0;
  assign bus.pc_we_o      = pc_we_q;
  assign bus.pc_o         = pc_q;
  assign busy_o           = busy_q;
  assign recovery_done_o  = done_q;

endmodule

// File: tb/tb_ft_recovery_seq.sv
// Directed bench for ft_recovery_seq: default instance against a scoreboard
// of expected writes / PC load / done, plus a 4-register instance.
module tb_ft_recovery_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic recover;
  logic recover2;
  logic busy, done, busy2, done2;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem  [32];
  logic [31:0] mem2 [4];

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t wq[$];
  exp_t pq[$];
  exp_t dq[$];

  ft_recovery_seq_if #(.ADDR_W(5), .DATA_W(32)) bus  ();
  ft_recovery_seq_if #(.ADDR_W(2), .DATA_W(32)) bus2 ();

  ft_recovery_seq #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .recover_i       (recover),
    .bus             (bus),
    .busy_o          (busy),
    .recovery_done_o (done)
  );

  ft_recovery_seq #(.NREGS(4), .ADDR_W(2), .DATA_W(32)) dut2 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .recover_i       (recover2),
    .bus             (bus2),
    .busy_o          (busy2),
    .recovery_done_o (done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency checkpoint stores
  always @(posedge clk) bus.ckpt_rdata_i  <= mem[bus.ckpt_raddr_o];
  always @(posedge clk) bus2.ckpt_rdata_i <= mem2[bus2.ckpt_raddr_o];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_seq(input int s);
    for (int i = 1; i < 32; i++) wq.push_back('{c: s + i + 1, a: 32'(i), d: mem[i]});
    pq.push_back('{c: s + 32, a: 32'd0, d: 32'h0000_0180});
    dq.push_back('{c: s + 33, a: 32'd0, d: 32'd0});
  endtask

  task automatic start_pulse(output int s);
    @(negedge clk);
    recover = 1'b1;
    s = cyc;
    @(negedge clk);
    recover = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((wq.size() + pq.size() + dq.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(wq.size() + pq.size() + dq.size()), 64'd0);
    wq.delete();
    pq.delete();
    dq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_raddr"}, 64'(bus.ckpt_raddr_o), 64'd0);
    chk({tag, "_we"},    64'(bus.rf_we_o),      64'd0);
    chk({tag, "_waddr"}, 64'(bus.rf_waddr_o),   64'd0);
    chk({tag, "_wdata"}, 64'(bus.rf_wdata_o),   64'd0);
    chk({tag, "_pcwe"},  64'(bus.pc_we_o),      64'd0);
    chk({tag, "_pc"},    64'(bus.pc_o),         64'd0);
    chk({tag, "_busy"},  64'(busy),             64'd0);
    chk({tag, "_done"},  64'(done),             64'd0);
  endtask

  // Output monitor for the default instance: every strobe must match the
  // head of its expectation queue, including the cycle it appears in.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.rf_we_o === 1'b1) begin
          chk("wr_pending", 64'(wq.size() != 0), 64'd1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr",  64'(bus.rf_waddr_o), 64'(e.a));
            chk("wr_data",  64'(bus.rf_wdata_o), 64'(e.d));
            chk("wr_cycle", 64'(cyc),            64'(e.c));
          end
        end
        if (bus.pc_we_o === 1'b1) begin
          chk("pc_pending", 64'(pq.size() != 0), 64'd1);
          if (pq.size() != 0) begin
            e = pq.pop_front();
            chk("pc_value", 64'(bus.pc_o), 64'(e.d));
            chk("pc_cycle", 64'(cyc),      64'(e.c));
          end
        end
        if (done === 1'b1) begin
          chk("done_pending", 64'(dq.size() != 0), 64'd1);
          if (dq.size() != 0) begin
            e = dq.pop_front();
            chk("done_cycle", 64'(cyc),  64'(e.c));
            chk("done_busy",  64'(busy), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    miscompares++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n    = 1'b0;
    enable   = 1'b1;
    recover  = 1'b0;
    recover2 = 1'b0;
    bus.ckpt_pc_i  = 32'h0000_0180;
    bus2.ckpt_pc_i = 32'h0000_0244;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 4; i++)  mem2[i] = 32'hB000_0000 + 32'(i);

    #3;
    chk_all_zero("reset");
    chk("reset_busy2", 64'(busy2), 64'd0);
    chk("reset_done2", 64'(done2), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic restore
    start_pulse(s);
    push_seq(s);
    for (int k = 1; k < 32; k++) begin
      wait_cyc(s + k);
      chk("basic_raddr", 64'(bus.ckpt_raddr_o), 64'(k));
      chk("basic_busy",  64'(busy),             64'd1);
    end
    wait_cyc(s + 33);
    chk("basic_done_busy", 64'(busy), 64'd1);
    wait_cyc(s + 34);
    chk("basic_busy_low", 64'(busy), 64'd0);
    drain(5);

    // held level: one sequence only
    @(negedge clk);
    recover = 1'b1;
    s = cyc;
    push_seq(s);
    repeat (100) @(negedge clk);
    recover = 1'b0;
    drain(10);
    chk("held_busy_low", 64'(busy), 64'd0);

    // gated by enable, then enable raised with recover still high
    repeat (3) @(negedge clk);
    enable = 1'b0;
    recover = 1'b1;
    repeat (40) @(negedge clk);
    chk("gated_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    chk("gated_late_en_busy", 64'(busy), 64'd0);
    recover = 1'b0;
    start_pulse(s);
    push_seq(s);
    drain(50);

    // retrigger while busy is ignored and does not extend the sequence
    repeat (3) @(negedge clk);
    start_pulse(s);
    push_seq(s);
    wait_cyc(s + 9);
    recover = 1'b1;
    @(negedge clk);
    recover = 1'b0;
    drain(50);
    repeat (40) @(negedge clk);
    chk("retrig_idle_busy", 64'(busy), 64'd0);

    // reset mid-operation, then a fresh full sequence
    start_pulse(s);
    push_seq(s);
    wait_cyc(s + 15);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    wq.delete();
    pq.delete();
    dq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_pulse(s);
    push_seq(s);
    wait_cyc(s + 1);
    chk("postrst_raddr", 64'(bus.ckpt_raddr_o), 64'd1);
    drain(50);

    // NREGS=4 / ADDR_W=2 instance
    repeat (3) @(negedge clk);
    recover2 = 1'b1;
    s = cyc;
    @(negedge clk);
    recover2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      wait_cyc(s + c);
      chk("p4_we",   64'(bus2.rf_we_o), 64'(c >= 2 && c <= 4));
      chk("p4_pcwe", 64'(bus2.pc_we_o), 64'(c == 4));
      chk("p4_done", 64'(done2),        64'(c == 5));
      chk("p4_busy", 64'(busy2),        64'(c <= 5));
      if (c <= 3) chk("p4_raddr", 64'(bus2.ckpt_raddr_o), 64'(c));
      if (c >= 2 && c <= 4) begin
        chk("p4_waddr", 64'(bus2.rf_waddr_o), 64'(c - 1));
        chk("p4_wdata", 64'(bus2.rf_wdata_o), 64'(mem2[c - 1]));
      end
      if (c == 4) chk("p4_pc", 64'(bus2.pc_o), 64'h244);
    end
    repeat (5) @(negedge clk);
    chk("p4_idle_we", 64'(bus2.rf_we_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
